// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Bit period in system clock cycles (integer divide).
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty come from the count, not the pointers.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is refused even if a pop happens in the same cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO in front of a start/data/[parity]/stop serialiser.
// Optional even parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic                     wr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     ovf_clr_i,
    output logic                     uart_tx,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o,
    output logic                     ovf_o,
    output uart_tx_state_t           state_o
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = $clog2(DATA_W + 1);

    uart_tx_state_t    state;
    uart_tx_state_t    state_nxt;
    logic [CNT_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] pop_data;
    logic              pop;
    logic              baud_tick;
    logic              last_data;
    logic              last_stop;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    // wr_i is a one-cycle strobe with no back-pressure: it is accepted at the edge
    // iff full_o was low during that cycle, otherwise dropped and ovf_o is set.
    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstd      (rstd),
        .push      (wr_i),
        .push_data (wr_data_i),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full_o),
        .empty     (empty_o),
        .count     (count_o)
    );

    assign baud_tick = (baud_cnt == CNT_W'(DIV - 1));
    assign last_data = (bit_cnt == BIT_W'(DATA_W - 1));
    assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign busy_o    = (state != IDLE);
    assign state_o   = state;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        uart_tx   = 1'b1;
        case (state)
            IDLE: begin
                if (!empty_o) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (baud_tick) state_nxt = DATA;
            end
            DATA: begin
                uart_tx = shift_q[0];
                if (baud_tick && last_data) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                uart_tx = parity_q;
                if (baud_tick) state_nxt = STOP;
            end
`endif
            STOP: begin
                uart_tx = 1'b1;
                if (baud_tick && last_stop) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // IDLE holds both counters at zero so START always begins a fresh bit period.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (pop) begin
                shift_q <= pop_data;
            end
        end else if (baud_tick) begin
            baud_cnt <= '0;
            if (state == DATA) begin
                shift_q <= shift_q >> 1;
                bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
            end else if (state == STOP) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^pop_data;
        end
    end
`endif

    // A dropped push outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            ovf_o <= 1'b0;
        end else if (wr_i && full_o) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

endmodule
